mem_arbiter: RTL and testbench

Sequences the single unified RAM port between the pipeline's instruction-fetch path and data-memory path. It accepts independent instruction-read and data-read/write requests, grants one at a time through a small state machine and drives the RAM enables, address and store data. It returns per-requester hits and load data. It sits between the caches/fetch stage and the RAM model, and produces the `ihit`/`dhit` that the control unit and pipeline stall logic consume.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake status and the memory arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arbstate_t;

  localparam int unsigned FAIR_CNT_W   = 3;
  localparam logic [FAIR_CNT_W-1:0] FAIR_CNT_MAX = '1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Optional MEMARB_FAIR_EN: bounds how many data grants may starve a waiting fetch.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      ihit,
  output word_t     iload,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      arb_err
);

  arbstate_t state, next_state;
  logic      dreq;
  logic      fair_override;

  assign dreq = dREN | dWEN;

`ifdef MEMARB_FAIR_EN
  logic [FAIR_CNT_W-1:0] fair_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fair_cnt <= '0;
    end else if (!iREN || ihit) begin
      fair_cnt <= '0;
    end else if (dhit && fair_cnt != FAIR_CNT_MAX) begin
      fair_cnt <= fair_cnt + 1'b1;
    end
  end

  assign fair_override = iREN && (32'(fair_cnt) >= FAIR_LIMIT);
`else
  logic unused_fair_limit;
  assign unused_fair_limit = ^FAIR_LIMIT;
  assign fair_override     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A grant ends on completion, error, or the requester withdrawing; each
  // path returns through IDLE so arbitration always gets its bubble cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (fair_override)  next_state = IGNT;
        else if (dreq)      next_state = DGNT;
        else if (iREN)      next_state = IGNT;
      end
      IGNT: begin
        if (!iREN || ramstate == ACCESS || ramstate == ERROR) next_state = IDLE;
      end
      DGNT: begin
        if (!dreq || ramstate == ACCESS || ramstate == ERROR) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    dhit     = 1'b0;
    arb_err  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = ramload;
    dload    = ramload;
    unique case (state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        ihit    = (ramstate == ACCESS);
        arb_err = (ramstate == ERROR);
      end
      DGNT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dhit     = (ramstate == ACCESS);
        arb_err  = (ramstate == ERROR);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle bench for mem_arbiter; fairness expectations follow MEMARB_FAIR_EN.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  ramstate_t ramstate;
  word_t     ramload;
  logic      ihit;
  word_t     iload;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  logic      arb_err;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.FAIR_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .arb_err(arb_err)
  );

  typedef logic [68:0] vec_t;
  typedef struct {
    logic      rst;
    logic      ir;
    logic      dr;
    logic      dw;
    ramstate_t rs;
    vec_t      exp;
  } step_t;

  function automatic vec_t pk(logic ih, logic dh, logic er, logic re, logic we,
                              word_t a, word_t s);
    return {ih, dh, er, re, we, a, s};
  endfunction

  function automatic vec_t obs();
    return {ihit, dhit, arb_err, ramREN, ramWEN, ramaddr, ramstore};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input step_t s);
    RST      = s.rst;
    iREN     = s.ir;
    dREN     = s.dr;
    dWEN     = s.dw;
    ramstate = s.rs;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
    iaddr = 32'h44; daddr = 32'h88; dstore = 32'h1; ramstate = ACCESS; ramload = '0;
    tick();
    tick();
    RST = 1'b0; iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (obs() !== pk(0, 0, 0, 0, 0, 0, 0)) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, obs(), pk(0, 0, 0, 0, 0, 0, 0));
      end
      checks++;
      if (iload !== 32'h0 || dload !== 32'h0) begin
        failures++;
        $display("FAIL reset_load cyc%0d got i=%h d=%h exp 0", i, iload, dload);
      end
      tick();
    end
  endtask

  task automatic test_ifetch();
    step_t s[6];
    iaddr = 32'h0000_0004; daddr = '0; dstore = '0; ramload = 32'h2408_0001;
    s[0] = '{1'b0, 1'b1, 1'b0, 1'b0, BUSY,   pk(0, 0, 0, 0, 0, 0, 0)};
    s[1] = '{1'b0, 1'b1, 1'b0, 1'b0, BUSY,   pk(0, 0, 0, 1, 0, 32'h4, 0)};
    s[2] = '{1'b0, 1'b1, 1'b0, 1'b0, BUSY,   pk(0, 0, 0, 1, 0, 32'h4, 0)};
    s[3] = '{1'b0, 1'b1, 1'b0, 1'b0, ACCESS, pk(1, 0, 0, 1, 0, 32'h4, 0)};
    s[4] = '{1'b0, 1'b0, 1'b0, 1'b0, FREE,   pk(0, 0, 0, 0, 0, 0, 0)};
    s[5] = '{1'b0, 1'b0, 1'b0, 1'b0, FREE,   pk(0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(negedge CLK);
      checks++;
      if (obs() !== s[i].exp) begin
        failures++;
        $display("FAIL ifetch cyc%0d got=%h exp=%h", i, obs(), s[i].exp);
      end
      if (i == 3) begin
        checks++;
        if (iload !== 32'h2408_0001) begin
          failures++;
          $display("FAIL ifetch_iload got=%h exp=24080001", iload);
        end
      end
      tick();
    end
  endtask

  task automatic test_data_priority();
    step_t s[5];
    iaddr = 32'h8; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramload = '0;
    s[0] = '{1'b0, 1'b1, 1'b0, 1'b1, ACCESS, pk(0, 0, 0, 0, 0, 0, 0)};
    s[1] = '{1'b0, 1'b1, 1'b0, 1'b1, ACCESS, pk(0, 1, 0, 0, 1, 32'h100, 32'hDEAD_BEEF)};
    s[2] = '{1'b0, 1'b1, 1'b0, 1'b0, FREE,   pk(0, 0, 0, 0, 0, 0, 0)};
    s[3] = '{1'b0, 1'b1, 1'b0, 1'b0, ACCESS, pk(1, 0, 0, 1, 0, 32'h8, 0)};
    s[4] = '{1'b0, 1'b0, 1'b0, 1'b0, FREE,   pk(0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      @(negedge CLK);
      checks++;
      if (obs() !== s[i].exp) begin
        failures++;
        $display("FAIL priority cyc%0d got=%h exp=%h", i, obs(), s[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_error();
    step_t s[5];
    iaddr = 32'hC; daddr = '0; dstore = '0;
    s[0] = '{1'b0, 1'b1, 1'b0, 1'b0, BUSY,   pk(0, 0, 0, 0, 0, 0, 0)};
    s[1] = '{1'b0, 1'b1, 1'b0, 1'b0, ERROR,  pk(0, 0, 1, 1, 0, 32'hC, 0)};
    s[2] = '{1'b0, 1'b1, 1'b0, 1'b0, BUSY,   pk(0, 0, 0, 0, 0, 0, 0)};
    s[3] = '{1'b0, 1'b1, 1'b0, 1'b0, ACCESS, pk(1, 0, 0, 1, 0, 32'hC, 0)};
    s[4] = '{1'b0, 1'b0, 1'b0, 1'b0, FREE,   pk(0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      @(negedge CLK);
      checks++;
      if (obs() !== s[i].exp) begin
        failures++;
        $display("FAIL error cyc%0d got=%h exp=%h", i, obs(), s[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_drop();
    step_t s[4];
    daddr = 32'h200; dstore = 32'h1234;
    s[0] = '{1'b0, 1'b0, 1'b1, 1'b0, BUSY, pk(0, 0, 0, 0, 0, 0, 0)};
    s[1] = '{1'b0, 1'b0, 1'b1, 1'b0, BUSY, pk(0, 0, 0, 1, 0, 32'h200, 32'h1234)};
    s[2] = '{1'b0, 1'b0, 1'b0, 1'b0, BUSY, pk(0, 0, 0, 0, 0, 32'h200, 32'h1234)};
    s[3] = '{1'b0, 1'b0, 1'b0, 1'b0, FREE, pk(0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 4; i++) begin
      apply(s[i]);
      @(negedge CLK);
      checks++;
      if (obs() !== s[i].exp) begin
        failures++;
        $display("FAIL drop cyc%0d got=%h exp=%h", i, obs(), s[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    step_t s[6];
    daddr = 32'h300; dstore = 32'hCAFE; ramload = 32'h5555_AAAA;
    s[0] = '{1'b0, 1'b0, 1'b1, 1'b0, BUSY,   pk(0, 0, 0, 0, 0, 0, 0)};
    s[1] = '{1'b0, 1'b0, 1'b1, 1'b0, BUSY,   pk(0, 0, 0, 1, 0, 32'h300, 32'hCAFE)};
    s[2] = '{1'b1, 1'b0, 1'b1, 1'b0, BUSY,   pk(0, 0, 0, 1, 0, 32'h300, 32'hCAFE)};
    s[3] = '{1'b0, 1'b0, 1'b1, 1'b0, ACCESS, pk(0, 0, 0, 0, 0, 0, 0)};
    s[4] = '{1'b0, 1'b0, 1'b1, 1'b0, ACCESS, pk(0, 1, 0, 1, 0, 32'h300, 32'hCAFE)};
    s[5] = '{1'b0, 1'b0, 1'b0, 1'b0, FREE,   pk(0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(negedge CLK);
      checks++;
      if (obs() !== s[i].exp) begin
        failures++;
        $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, obs(), s[i].exp);
      end
      if (i == 4) begin
        checks++;
        if (dload !== 32'h5555_AAAA) begin
          failures++;
          $display("FAIL reset_mid_dload got=%h exp=5555aaaa", dload);
        end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    int   n_dhit  = 0;
    logic seen_i  = 1'b0;
    logic both    = 1'b0;
    int   exp_dhit;
    logic exp_seen;
`ifdef MEMARB_FAIR_EN
    exp_dhit = 4;
    exp_seen = 1'b1;
`else
    exp_dhit = 12;
    exp_seen = 1'b0;
`endif
    iaddr = 32'h40; daddr = 32'h400; dstore = '0; ramload = '0;
    RST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramstate = ACCESS;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      if (ihit && dhit) both = 1'b1;
      if (ihit) begin
        seen_i = 1'b1;
        tick();
        break;
      end
      if (dhit) n_dhit++;
      tick();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick();
    tick();
    checks++;
    if (seen_i !== exp_seen) begin
      failures++;
      $display("FAIL fair_ihit got=%0b exp=%0b", seen_i, exp_seen);
    end
    checks++;
    if (n_dhit != exp_dhit) begin
      failures++;
      $display("FAIL fair_dhits got=%0d exp=%0d", n_dhit, exp_dhit);
    end
    checks++;
    if (both !== 1'b0) begin
      failures++;
      $display("FAIL fair_both_hits got=%0b exp=0", both);
    end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_data_priority();
    test_error();
    test_drop();
    test_reset_mid_access();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
